uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requester channels (2..8).
REQ-002 The block SHALL have parameter BAUD_DIV, default 434, giving clock cycles per baud pulse (>=2).
REQ-003 The block SHALL have parameter HOLD_TO, default 1023, giving idle cycles allowed mid-message before forced release (>=1).
REQ-004 Port i_clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 Port i_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port i_req_data, input, N_REQ*8 bits: byte from requester k on bits [8k+7:8k].
REQ-007 Port i_req_valid, input, N_REQ bits: byte valid per requester.
REQ-008 Port i_req_last, input, N_REQ bits: the current byte is the final byte of the message, per requester.
REQ-009 Port o_req_ready, output, N_REQ bits: byte accepted from requester k when valid[k] and ready[k] are both high.
REQ-010 Port o_data, output, 8 bits: byte to the UART transmitter stream input.
REQ-011 Port o_valid, output, 1 bit: byte valid to the transmitter.
REQ-012 Port i_ready, input, 1 bit: transmitter ready.
REQ-013 Port o_txpulse, output, 1 bit: single-cycle baud pulse to the transmitter.
REQ-014 Port o_grant, output, 3 bits: index of the requester currently granted.
REQ-015 Port o_busy, output, 1 bit: high while a requester holds the grant.
REQ-016 Port o_timeout, output, 1 bit: single-cycle pulse when a grant is force-released.

Function
REQ-017 The baud counter SHALL count 0..BAUD_DIV-1 and wrap, free-running; o_txpulse SHALL be registered and high for exactly one cycle per wrap, with period BAUD_DIV.
REQ-018 The FSM SHALL have states S_ARB and S_PASS; any other encoding SHALL return to S_ARB.
REQ-019 In S_ARB, when any i_req_valid bit is high, the block SHALL grant round-robin: first valid index strictly after the last-granted pointer, wrapping modulo N_REQ; it SHALL register o_grant, set o_busy=1, and enter S_PASS on the next cycle.
REQ-020 In S_ARB, o_valid and all o_req_ready bits SHALL be 0; with no valid bits, the state SHALL hold.
REQ-021 In S_PASS, o_data SHALL equal byte[o_grant]; o_valid SHALL equal i_req_valid[o_grant]; o_req_ready[o_grant] SHALL equal i_ready; all other ready bits SHALL be 0. This path is combinational with zero latency.
REQ-022 A transfer occurs on a cycle with o_valid and i_ready both high; a transfer with i_req_last[o_grant]=1 SHALL set pointer=o_grant, clear o_busy, and return to S_ARB.
REQ-023 Grant SHALL be held across non-last bytes; other requesters SHALL NOT be served mid-message.
REQ-024 The hold counter SHALL reset to 0 on every transfer and on grant; it SHALL increment on each S_PASS cycle with i_req_valid[o_grant]=0.
REQ-025 When the hold counter reaches HOLD_TO, the block SHALL pulse o_timeout for one cycle, set pointer=o_grant, clear o_busy, and return to S_ARB.
REQ-026 Cycles with valid high but i_ready low SHALL NOT advance the hold counter; backpressure is never a timeout.
REQ-027 Minimum arbitration overhead SHALL be one cycle in S_ARB between messages.
REQ-028 If a single-byte message has last=1 on its first byte, the block SHALL behave as in REQ-022.

Reset
REQ-029 While i_rst=0, asynchronously: state=S_ARB, pointer=N_REQ-1 (so requester 0 has first priority), o_grant=0, o_busy=0, o_timeout=0, o_txpulse=0, baud counter=0, hold counter=0; o_valid=0 and o_req_ready=0.
REQ-030 Reset asserted mid-message SHALL abort it; no byte SHALL be transferred on the reset-release edge; arbitration SHALL restart from requester 0.

Verification
REQ-031 BAUD_DIV=4, reset released -> o_txpulse high on cycles 4, 8, 12 after release; one cycle wide.
REQ-032 Requesters 0 and 2 each present one byte (0xA5, 0x3C) with last=1; i_ready=1 -> output 0xA5 then 0x3C; o_grant 0 then 2; one S_ARB cycle between them.
REQ-033 Requester 1 sends 3 bytes (last on the 3rd); requester 0 is valid throughout -> all 3 bytes from 1 are contiguous, then 0 is granted.
REQ-034 With i_ready held low 2000 cycles while valid=1 (HOLD_TO=1023) -> no o_timeout; the byte transfers when i_ready rises.
REQ-035 Granted requester drops valid after its 1st non-last byte; HOLD_TO=8 -> o_timeout pulses 8 cycles later; o_busy=0; the next valid requester is granted.
REQ-036 i_rst pulled low during the 2nd byte of a message -> all outputs at reset values immediately; after release, requester 0 wins if valid.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between N_REQ byte-stream requesters. A
// requester keeps the grant for a whole message, up to and including the
// byte flagged "last". Grants rotate round-robin, starting after the
// requester that was granted most recently. A free-running baud divider
// supplies the transmitter's bit-rate pulse.
//
// If a granted requester stops presenting bytes in the middle of a message
// for HOLD_TO cycles, its grant is taken away. Cycles where the requester
// is presenting a byte but the transmitter is not ready do not count toward
// that limit.
//
// Parameters
//   N_REQ    : number of requester channels (2..8)
//   BAUD_DIV : clock cycles per baud pulse (>= 2)
//   HOLD_TO  : idle cycles tolerated mid-message before forced release (>= 1)
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst        : asynchronous active-low reset
//   i_req_data   : per-requester byte, requester k on [8k+7:8k]
//   i_req_valid  : per-requester byte valid
//   i_req_last   : per-requester "this byte ends the message"
//   o_req_ready  : per-requester accept (only the granted bit can be high)
//   o_data       : byte to the transmitter
//   o_valid      : byte valid to the transmitter
//   i_ready      : transmitter ready
//   o_txpulse    : one-cycle baud pulse, period BAUD_DIV
//   o_grant      : index of the requester currently (or last) granted
//   o_busy       : high while a requester holds the grant
//   o_timeout    : one-cycle pulse when a grant is force-released
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int BAUD_DIV = 434,
    parameter int HOLD_TO  = 1023
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ*8-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [N_REQ-1:0]   i_req_last,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [7:0]         o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_txpulse,
    output logic [2:0]         o_grant,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int HW = $clog2(HOLD_TO + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TO - 1);
    localparam logic [2:0]    PTR_INIT  = 3'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_PASS = 2'd1
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t         state_reg,   state_next;
    logic [2:0]     ptr_reg,     ptr_next;
    logic [2:0]     grant_reg,   grant_next;
    logic           busy_reg,    busy_next;
    logic           timeout_reg, timeout_next;
    logic [HW-1:0]  hold_reg,    hold_next;
    logic [BW-1:0]  baud_reg,    baud_next;
    logic           pulse_reg,   pulse_next;

    // -----------------------------------------------------------------------
    // Requester inputs padded out to the full 3-bit index space, so that a
    // 3-bit grant/candidate index can select them directly for any N_REQ.
    // Unused slots read as "not valid".
    // -----------------------------------------------------------------------
    logic [7:0] req_byte [8];
    logic [7:0] valid_pad;
    logic [7:0] last_pad;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
        if (gi < N_REQ) begin : g_live
            assign req_byte[gi]  = i_req_data[gi*8 +: 8];
            assign valid_pad[gi] = i_req_valid[gi];
            assign last_pad[gi]  = i_req_last[gi];
        end else begin : g_tie
            assign req_byte[gi]  = 8'h00;
            assign valid_pad[gi] = 1'b0;
            assign last_pad[gi]  = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin candidates: candidate gi is the requester (gi+1) places
    // after the pointer, wrapped into 0..N_REQ-1. The pointer is always a
    // legal index, so one conditional subtraction is enough for the wrap.
    // -----------------------------------------------------------------------
    logic [3:0]       cand_sum [N_REQ];
    logic [2:0]       cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        assign cand_sum[gi] = {1'b0, ptr_reg} + 4'(gi + 1);
        assign cand_idx[gi] = (cand_sum[gi] >= 4'(N_REQ))
                            ? 3'(cand_sum[gi] - 4'(N_REQ))
                            : cand_sum[gi][2:0];
        assign cand_hit[gi] = valid_pad[cand_idx[gi]];
    end

    logic       arb_found;
    logic [2:0] arb_idx;

    // The nearest candidate after the pointer wins: scan from the farthest
    // so the closest hit is the last assignment.
    always_comb begin
        arb_found = |cand_hit;
        arb_idx   = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                arb_idx = cand_idx[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pass-through path (combinational while a grant is held)
    // -----------------------------------------------------------------------
    logic pass;
    logic xfer;

    assign pass    = (state_reg == S_PASS);
    assign o_data  = pass ? req_byte[grant_reg] : 8'h00;
    assign o_valid = pass && valid_pad[grant_reg];
    assign xfer    = o_valid && i_ready;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign o_req_ready[gi] = pass && i_ready && (grant_reg == 3'(gi));
    end

    assign o_grant   = grant_reg;
    assign o_busy    = busy_reg;
    assign o_timeout = timeout_reg;
    assign o_txpulse = pulse_reg;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        grant_next   = grant_reg;
        busy_next    = busy_reg;
        hold_next    = hold_reg;
        timeout_next = 1'b0;

        // Free-running baud divider; the pulse is registered on the wrap.
        if (baud_reg == BAUD_LAST) begin
            baud_next  = '0;
            pulse_next = 1'b1;
        end else begin
            baud_next  = baud_reg + BW'(1);
            pulse_next = 1'b0;
        end

        case (state_reg)
            S_ARB: begin
                busy_next = 1'b0;
                if (arb_found) begin
                    grant_next = arb_idx;
                    busy_next  = 1'b1;
                    hold_next  = '0;
                    state_next = S_PASS;
                end
            end

            S_PASS: begin
                if (xfer) begin
                    hold_next = '0;
                    if (last_pad[grant_reg]) begin
                        ptr_next   = grant_reg;
                        busy_next  = 1'b0;
                        state_next = S_ARB;
                    end
                end else if (!valid_pad[grant_reg]) begin
                    // Only a silent requester ages the grant; a byte held
                    // off by transmitter backpressure does not.
                    if (hold_reg == HOLD_LAST) begin
                        timeout_next = 1'b1;
                        ptr_next     = grant_reg;
                        busy_next    = 1'b0;
                        hold_next    = '0;
                        state_next   = S_ARB;
                    end else begin
                        hold_next = hold_reg + HW'(1);
                    end
                end
            end

            default: begin
                state_next = S_ARB;
                busy_next  = 1'b0;
                hold_next  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg   <= S_ARB;
            ptr_reg     <= PTR_INIT;
            grant_reg   <= 3'd0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            hold_reg    <= '0;
            baud_reg    <= '0;
            pulse_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
            hold_reg    <= hold_next;
            baud_reg    <= baud_next;
            pulse_reg   <= pulse_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Each requester is fed from its own byte FIFO of messages. Every cycle the
// DUT outputs are compared against a behavioural model that tracks which
// requester owns the transmitter, the round-robin pointer, idle time and
// the baud phase. Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BD = 4;
    localparam int HT = 8;

    logic           clk = 1'b0;
    logic           i_rst;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     o_data;
    logic           o_valid;
    logic           i_ready;
    logic           o_txpulse;
    logic [2:0]     o_grant;
    logic           o_busy;
    logic           o_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ    (N),
        .BAUD_DIV (BD),
        .HOLD_TO  (HT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_data  (req_data),
        .i_req_valid (req_valid),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_txpulse   (o_txpulse),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    // Sources
    logic [8:0] src_mem [N][256];
    int         src_rd [N];
    int         src_wr [N];
    int         gap_cnt [N];
    bit         gap_after_first [N];
    int         rdy_mode;          // 0 random, 1 high, 2 low
    bit         rand_gaps;
    bit         refill;
    bit         rst_mid;
    bit         release_pending;

    // Driven values of the current cycle
    logic [N-1:0] v_drv;
    logic [N-1:0] l_drv;
    logic [7:0]   d_drv [N];
    logic         r_drv;

    // Behavioural model
    int owner;        // -1 when nobody holds the transmitter
    int ptr;
    int mgrant;
    int idle;
    int edge_cnt;
    int cyc;
    bit exp_pulse;
    bit exp_timeout;

    int log_req [$];
    int log_data [$];
    int log_cyc [$];
    int to_cyc;
    int to_count;
    bit pulse_seen [16];

    int tests_run;
    int tests_failed;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] b, input bit last);
        src_mem[k][src_wr[k] % 256] = {last, b};
        src_wr[k]++;
    endtask

    task automatic flush_sources();
        for (int k = 0; k < N; k++) begin
            src_rd[k]          = src_wr[k];
            gap_cnt[k]         = 0;
            gap_after_first[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        owner       = -1;
        ptr         = N - 1;
        mgrant      = 0;
        idle        = 0;
        edge_cnt    = 0;
        exp_pulse   = 1'b0;
        exp_timeout = 1'b0;
    endtask

    function automatic bit pending();
        bit p = (owner >= 0);
        for (int k = 0; k < N; k++) begin
            if (src_rd[k] != src_wr[k]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drive_inputs();
        logic [8:0] entry;
        bit         has;
        if (release_pending) begin
            i_rst           = 1'b1;
            release_pending = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (refill && src_rd[k] == src_wr[k] && ($urandom % 6) == 0) begin
                int len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) push_byte(k, 8'($urandom), i == len - 1);
            end
            if (rand_gaps && gap_cnt[k] == 0 && ($urandom % 10) == 0)
                gap_cnt[k] = (($urandom % 16) == 0) ? HT + 3 : $urandom_range(1, 4);
            has      = (src_rd[k] != src_wr[k]);
            entry    = src_mem[k][src_rd[k] % 256];
            v_drv[k] = has && gap_cnt[k] == 0;
            d_drv[k] = has ? entry[7:0] : 8'($urandom);
            l_drv[k] = has ? entry[8] : 1'($urandom);
        end
        case (rdy_mode)
            0:       r_drv = (($urandom % 4) != 0);
            1:       r_drv = 1'b1;
            default: r_drv = 1'b0;
        endcase
        req_valid = v_drv;
        req_last  = l_drv;
        for (int k = 0; k < N; k++) req_data[k*8 +: 8] = d_drv[k];
        i_ready = r_drv;
    endtask

    task automatic compare();
        logic [N-1:0] er;
        er = '0;
        if (owner >= 0 && r_drv) er[owner] = 1'b1;
        check_val("valid", o_valid, (owner >= 0) && v_drv[owner]);
        check_val("ready", req_ready, er);
        if (owner >= 0) check_val("data", o_data, d_drv[owner]);
        check_val("busy", o_busy, owner >= 0);
        check_val("grant", o_grant, mgrant);
        check_val("timeout", o_timeout, exp_timeout);
        check_val("txpulse", o_txpulse, exp_pulse);
        if (o_timeout === 1'b1) begin
            to_count++;
            to_cyc = cyc;
        end
        if (edge_cnt < 16) pulse_seen[edge_cnt] = o_txpulse;
    endtask

    task automatic model_step();
        bit found;
        if (i_rst !== 1'b1) begin
            model_reset();
            return;
        end
        cyc++;
        edge_cnt++;
        exp_pulse   = (edge_cnt % BD) == 0;
        exp_timeout = 1'b0;
        for (int k = 0; k < N; k++) if (gap_cnt[k] > 0) gap_cnt[k]--;
        if (owner < 0) begin
            found = 1'b0;
            for (int off = 1; off <= N; off++) begin
                int k = (ptr + off) % N;
                if (!found && v_drv[k]) begin
                    found  = 1'b1;
                    owner  = k;
                    mgrant = k;
                    idle   = 0;
                end
            end
        end else if (v_drv[owner] && r_drv) begin
            $display("[TB] xfer cyc=%0d req=%0d data=%02h last=%0b", cyc, owner, d_drv[owner], l_drv[owner]);
            log_req.push_back(owner);
            log_data.push_back(int'(d_drv[owner]));
            log_cyc.push_back(cyc);
            src_rd[owner]++;
            if (gap_after_first[owner]) begin
                gap_cnt[owner]         = 200;
                gap_after_first[owner] = 1'b0;
            end
            idle = 0;
            if (l_drv[owner]) begin
                ptr   = owner;
                owner = -1;
            end
        end else if (!v_drv[owner]) begin
            idle++;
            if (idle == HT) begin
                exp_timeout = 1'b1;
                ptr         = owner;
                owner       = -1;
                idle        = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive_inputs();
        #1;
        compare();
        if (rst_mid) begin
            rst_mid = 1'b0;
            #1 i_rst = 1'b0;
            #1;
            model_reset();
            flush_sources();
            check_val("rst_valid", o_valid, 0);
            check_val("rst_ready", req_ready, 0);
            check_val("rst_busy", o_busy, 0);
            check_val("rst_grant", o_grant, 0);
            check_val("rst_timeout", o_timeout, 0);
            check_val("rst_txpulse", o_txpulse, 0);
        end
        @(posedge clk);
        model_step();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (pending() && n < max_cyc) begin
            tick();
            n++;
        end
        check_val("drained", pending(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int t0;
        int n;
        tests_run = 0; tests_failed = 0;
        cyc = 0; to_count = 0; to_cyc = 0;
        rdy_mode = 1; rand_gaps = 0; refill = 0; rst_mid = 0; release_pending = 0;
        for (int k = 0; k < N; k++) begin
            src_rd[k] = 0; src_wr[k] = 0; gap_cnt[k] = 0; gap_after_first[k] = 0;
            d_drv[k] = 8'h00;
        end
        v_drv = '0; l_drv = '0; r_drv = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; i_ready = 1'b0;
        i_rst = 1'b0;
        model_reset();

        // Reset state, then baud pulses at cycles 4, 8, 12 after release
        repeat (3) tick();
        release_pending = 1'b1;
        repeat (14) tick();
        for (int c = 1; c <= 12; c++) check_val("baud_phase", pulse_seen[c], (c % BD) == 0);

        // Two single-byte messages from requesters 0 and 2
        b = log_req.size();
        push_byte(0, 8'hA5, 1'b1);
        push_byte(2, 8'h3C, 1'b1);
        drain(50);
        check_val("rr_first_req", log_req[b], 0);
        check_val("rr_first_data", log_data[b], 8'hA5);
        check_val("rr_second_req", log_req[b+1], 2);
        check_val("rr_second_data", log_data[b+1], 8'h3C);
        check_val("rr_arb_gap", log_cyc[b+1] - log_cyc[b], 2);

        // Requester 1 holds the grant for its whole 3-byte message
        b = log_req.size();
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h12, 1'b0);
        push_byte(1, 8'h13, 1'b1);
        tick();
        push_byte(0, 8'h40, 1'b1);
        drain(50);
        check_val("msg_req0", log_req[b], 1);
        check_val("msg_req1", log_req[b+1], 1);
        check_val("msg_req2", log_req[b+2], 1);
        check_val("msg_contig1", log_cyc[b+1] - log_cyc[b], 1);
        check_val("msg_contig2", log_cyc[b+2] - log_cyc[b+1], 1);
        check_val("msg_then_0", log_req[b+3], 0);

        // Long backpressure never times out
        b = log_req.size();
        t0 = to_count;
        push_byte(1, 8'h77, 1'b1);
        rdy_mode = 2;
        repeat (200) tick();
        check_val("bp_no_timeout", to_count - t0, 0);
        check_val("bp_no_xfer", log_req.size() - b, 0);
        check_val("bp_busy", o_busy, 1);
        check_val("bp_grant", o_grant, 1);
        rdy_mode = 1;
        drain(50);
        check_val("bp_xfer_req", log_req[b], 1);
        check_val("bp_xfer_data", log_data[b], 8'h77);

        // Granted requester goes silent mid-message
        b = log_req.size();
        t0 = to_count;
        push_byte(2, 8'h21, 1'b0);
        push_byte(2, 8'h22, 1'b1);
        gap_after_first[2] = 1'b1;
        push_byte(3, 8'h33, 1'b1);
        n = 0;
        while (to_count == t0 && n < 60) begin
            tick();
            n++;
        end
        check_val("to_seen", to_count - t0, 1);
        check_val("to_delay", to_cyc - log_cyc[b], HT);
        check_val("to_busy", o_busy, 0);
        drain(600);
        check_val("to_first", log_req[b], 2);
        check_val("to_next_req", log_req[b+1], 3);
        check_val("to_next_data", log_data[b+1], 8'h33);

        // Randomized traffic
        rdy_mode = 0; rand_gaps = 1; refill = 1;
        repeat (1500) tick();
        rand_gaps = 0; refill = 0; rdy_mode = 1;
        for (int k = 0; k < N; k++) gap_cnt[k] = 0;
        drain(3000);

        // Reset during the second byte of a message
        b = log_req.size();
        push_byte(1, 8'h81, 1'b0);
        push_byte(1, 8'h82, 1'b0);
        push_byte(1, 8'h83, 1'b1);
        n = 0;
        while (log_req.size() == b && n < 20) begin
            tick();
            n++;
        end
        check_val("rst_pre_xfer", log_req.size() - b, 1);
        rst_mid = 1'b1;
        tick();
        repeat (2) tick();
        push_byte(1, 8'h66, 1'b1);
        push_byte(0, 8'h5A, 1'b1);
        b = log_req.size();
        release_pending = 1'b1;
        drain(50);
        check_val("rst_after_req", log_req[b], 0);
        check_val("rst_after_data", log_data[b], 8'h5A);
        check_val("rst_then_req", log_req[b+1], 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
